multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/mc_decode.sv | 30 +++
 rtl/multicycle_control.sv | 109 ++++++++++
 tb/tb_multicycle_control.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: state, ALU, opcode/funct and instruction-class encodings shared by the multicycle controller
package cpu_pkg;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_XOR = 3'd2,
      ALU_SLT = 3'd3
   } alu_t;

   typedef enum logic [3:0] {
      I_BAD, I_LW, I_SW, I_J, I_JAL, I_BEQ, I_BNE, I_ADDI, I_XORI, I_ADD, I_SUB, I_SLT, I_JR
   } insn_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_SEXT = 2'd1;
   localparam logic [1:0] SRCB_ZEXT = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies opcode/funct into an instruction class plus its ALU command and operand-B select
module mc_decode
   import cpu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] fn,
   output logic [3:0] insn,
   output logic [2:0] alu_cmd,
   output logic [1:0] alu_src_b
);
   always_comb begin
      insn = I_BAD;
      case (op)
         OP_R:    insn = fn == FN_ADD ? I_ADD : fn == FN_SUB ? I_SUB : fn == FN_SLT ? I_SLT : fn == FN_JR ? I_JR : I_BAD;
         OP_J:    insn = I_J;
         OP_JAL:  insn = I_JAL;
         OP_BEQ:  insn = I_BEQ;
         OP_BNE:  insn = I_BNE;
         OP_ADDI: insn = I_ADDI;
         OP_XORI: insn = I_XORI;
         OP_LW:   insn = I_LW;
         OP_SW:   insn = I_SW;
         default: insn = I_BAD;
      endcase
   end

   assign alu_cmd   = insn inside {I_SUB, I_BEQ, I_BNE} ? ALU_SUB : insn == I_XORI ? ALU_XOR :
                      insn == I_SLT ? ALU_SLT : ALU_ADD;
   assign alu_src_b = insn inside {I_LW, I_SW, I_ADDI} ? SRCB_SEXT : insn == I_XORI ? SRCB_ZEXT : SRCB_REG;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR, memory wait timer and retire counter
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 16,
   parameter int              CNT_W    = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr_in,
   input  logic             mem_ready,
   input  logic             alu_zero,
   input  logic [31:0]      rs_data,
   output logic [PC_W-1:0]  pc,
   output logic [31:0]      ir,
   output logic [2:0]       state,
   output logic             mem_req,
   output logic             mem_wr,
   output logic             reg_wr,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic             pc_to_reg,
   output logic [1:0]       reg_dst,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_cmd,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);
   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_t          st;
   logic [3:0]      insn;
   logic [2:0]      dec_cmd;
   logic [1:0]      dec_srcb;
   logic [WC_W-1:0] wcnt;
   logic            waiting, expired, taken, retire;
   logic [PC_W-1:0] j_tgt, b_tgt;

   mc_decode u_dec (
      .op        (ir[31:26]),
      .fn        (ir[5:0]),
      .insn      (insn),
      .alu_cmd   (dec_cmd),
      .alu_src_b (dec_srcb)
   );

   assign waiting = (st == S_FETCH || st == S_MEM) && !mem_ready;
   assign expired = waiting && wcnt == WC_W'(TIMEOUT - 1);
   assign taken   = insn == I_BEQ ? alu_zero : !alu_zero;
   assign j_tgt   = PC_W'({pc[PC_W-1:PC_W-4], ir[25:0], 2'b00});
   assign b_tgt   = pc + PC_W'($signed({ir[15:0], 2'b00}));
   // every path that lands back in FETCH from a live instruction retires it
   assign retire  = st == S_WB || (st == S_MEM && mem_ready && insn == I_SW) ||
                    (st == S_EXEC && insn inside {I_BEQ, I_BNE, I_JR}) ||
                    (st == S_DECODE && insn inside {I_J, I_JAL});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         retired <= '0;
         fault   <= 1'b0;
         wcnt    <= '0;
      end else begin
         wcnt    <= waiting ? wcnt + WC_W'(1) : '0;
         retired <= retired + CNT_W'(retire);
         fault   <= fault || expired || (st == S_DECODE && insn == I_BAD);
         case (st)
            S_FETCH:
               if (mem_ready) begin
                  ir <= instr_in;
                  pc <= pc + PC_W'(4);
                  st <= S_DECODE;
               end else if (expired) st <= S_FAULT;
            S_DECODE:
               if (insn == I_BAD) st <= S_FAULT;
               else if (insn == I_J || insn == I_JAL) begin
                  pc <= j_tgt;
                  st <= S_FETCH;
               end else st <= S_EXEC;
            S_EXEC:
               if (insn == I_LW || insn == I_SW) st <= S_MEM;
               else if (insn inside {I_BEQ, I_BNE, I_JR}) begin
                  pc <= insn == I_JR ? PC_W'(rs_data) : taken ? b_tgt : pc;
                  st <= S_FETCH;
               end else st <= S_WB;
            S_MEM:
               if (mem_ready) st <= insn == I_SW ? S_FETCH : S_WB;
               else if (expired) st <= S_FAULT;
            S_WB:    st <= S_FETCH;
            default: st <= S_FAULT;
         endcase
      end
   end

   assign state      = st;
   assign mem_req    = st == S_FETCH || st == S_MEM;
   assign mem_wr     = st == S_MEM && insn == I_SW;
   assign pc_to_reg  = st == S_DECODE && insn == I_JAL;
   assign reg_wr     = st == S_WB || pc_to_reg;
   assign mem_to_reg = st == S_WB && insn == I_LW;
   assign reg_dst    = pc_to_reg ? DST_RA : st == S_WB && insn inside {I_ADD, I_SUB, I_SLT} ? DST_RD : DST_RT;
   assign alu_src_a  = st inside {S_EXEC, S_MEM, S_WB};
   assign alu_cmd    = st == S_FAULT ? ALU_ADD : dec_cmd;
   assign alu_src_b  = st == S_FAULT ? SRCB_REG : dec_srcb;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction phase model with randomized memory latency against multicycle_control
module tb_multicycle_control;
   localparam int TO = 16;
   localparam int K_BAD = 0, K_LW = 1, K_SW = 2, K_J = 3, K_JAL = 4, K_BEQ = 5, K_BNE = 6,
                  K_ADDI = 7, K_XORI = 8, K_ADD = 9, K_SUB = 10, K_SLT = 11, K_JR = 12;

   logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
   logic [31:0] instr_in = '0, rs_data = '0;
   logic [31:0] pc, ir, retired;
   logic [2:0]  state, alu_cmd;
   logic        mem_req, mem_wr, reg_wr, mem_to_reg, alu_src_a, pc_to_reg, fault;
   logic [1:0]  reg_dst, alu_src_b;
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic [2:0] st;
      logic       req, wr, rw;
      logic [1:0] rd;
      logic       m2r, p2r, rdy;
   } cyc_t;
   cyc_t        q[$];
   logic [31:0] mpc, mir, mret;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .rs_data(rs_data), .pc(pc), .ir(ir), .state(state), .mem_req(mem_req), .mem_wr(mem_wr),
      .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .pc_to_reg(pc_to_reg),
      .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_cmd(alu_cmd), .fault(fault), .retired(retired)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int kind(logic [31:0] i);
      logic [5:0] op, fn;
      op = i[31:26];
      fn = i[5:0];
      if (op == 6'h00) return fn == 6'h20 ? K_ADD : fn == 6'h22 ? K_SUB : fn == 6'h2A ? K_SLT : fn == 6'h08 ? K_JR : K_BAD;
      return op == 6'h23 ? K_LW : op == 6'h2B ? K_SW : op == 6'h02 ? K_J : op == 6'h03 ? K_JAL :
             op == 6'h04 ? K_BEQ : op == 6'h05 ? K_BNE : op == 6'h08 ? K_ADDI : op == 6'h0E ? K_XORI : K_BAD;
   endfunction

   function automatic logic [4:0] alu_exp(int k);
      logic [2:0] c;
      logic [1:0] b;
      c = (k == K_SUB || k == K_BEQ || k == K_BNE) ? 3'd1 : k == K_XORI ? 3'd2 : k == K_SLT ? 3'd3 : 3'd0;
      b = (k == K_LW || k == K_SW || k == K_ADDI) ? 2'd1 : k == K_XORI ? 2'd2 : 2'd0;
      return {c, b};
   endfunction

   function automatic void push(int s, bit req, bit wr, bit rw, int rd, bit m2r, bit p2r, bit rdy);
      cyc_t c;
      c.st = 3'(s); c.req = req; c.wr = wr; c.rw = rw; c.rd = 2'(rd); c.m2r = m2r; c.p2r = p2r; c.rdy = rdy;
      q.push_back(c);
   endfunction

   function automatic void to_fault();
      for (int k = 0; k < 4; k++) push(5, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // n idle cycles then a ready cycle, or a timeout into FAULT when n reaches the limit
   function automatic bit wait_phase(int s, int n, bit wr);
      for (int k = 0; k < n && k < TO; k++) push(s, 1, wr, 0, 0, 0, 0, 0);
      if (n >= TO) begin
         to_fault();
         return 0;
      end
      push(s, 1, wr, 0, 0, 0, 0, 1);
      return 1;
   endfunction

   function automatic void build(logic [31:0] i, int fd, int md, bit z, logic [31:0] rs);
      int k;
      k = kind(i);
      if (!wait_phase(0, fd, 0)) return;
      mpc = mpc + 4;
      mir = i;
      push(1, 0, 0, k == K_JAL, k == K_JAL ? 2 : 0, 0, k == K_JAL, 0);
      if (k == K_BAD) begin
         to_fault();
         return;
      end
      if (k == K_J || k == K_JAL) begin
         mpc = {mpc[31:28], i[25:0], 2'b00};
         mret++;
         return;
      end
      push(2, 0, 0, 0, 0, 0, 0, 0);
      if (k == K_BEQ || k == K_BNE) begin
         if ((k == K_BEQ) == z) mpc = mpc + {{14{i[15]}}, i[15:0], 2'b00};
         mret++;
         return;
      end
      if (k == K_JR) begin
         mpc = rs;
         mret++;
         return;
      end
      if (k == K_LW || k == K_SW) begin
         if (!wait_phase(3, md, k == K_SW)) return;
         if (k == K_SW) begin
            mret++;
            return;
         end
      end
      push(4, 0, 0, 1, k >= K_ADD ? 1 : 0, k == K_LW, 0, 0);
      mret++;
   endfunction

   task automatic run(string name, logic [31:0] i, int fd, int md, bit z, logic [31:0] rs);
      int kk, cyc;
      kk = kind(i);
      cyc = 0;
      build(i, fd, md, z, rs);
      instr_in = i;
      alu_zero = z;
      rs_data = rs;
      while (q.size() > 0) begin
         cyc_t c;
         c = q.pop_front();
         n_chk++;
         if ({state, mem_req, mem_wr, reg_wr, reg_wr ? reg_dst : 2'b00, reg_wr & mem_to_reg, reg_wr & pc_to_reg, fault}
             !== {c.st, c.req, c.wr, c.rw, c.rd, c.m2r, c.p2r, c.st == 3'd5}) begin
            n_fail++;
            $display("FAIL %s cycle %0d [st req wr rw rd m2r p2r flt]: got %0d %b %b %b %0d %b %b %b, want %0d %b %b %b %0d %b %b %b",
                     name, cyc, state, mem_req, mem_wr, reg_wr, reg_dst, mem_to_reg, pc_to_reg, fault,
                     c.st, c.req, c.wr, c.rw, c.rd, c.m2r, c.p2r, c.st == 3'd5);
         end
         if (c.st inside {3'd2, 3'd3, 3'd4} && kk != K_JR) begin
            n_chk++;
            if ({alu_cmd, alu_src_b} !== alu_exp(kk)) begin
               n_fail++;
               $display("FAIL %s alu cycle %0d: got cmd=%0d srcb=%0d, want %b", name, cyc, alu_cmd, alu_src_b, alu_exp(kk));
            end
         end
         mem_ready = (c.st == 3'd0 || c.st == 3'd3) ? c.rdy : 1'($urandom);
         cyc++;
         @(negedge clk);
      end
      n_chk++;
      if ({pc, ir, retired} !== {mpc, mir, mret}) begin
         n_fail++;
         $display("FAIL %s end: got pc=%h ir=%h retired=%0d, want pc=%h ir=%h retired=%0d", name, pc, ir, retired, mpc, mir, mret);
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_chk++;
      if ({state, pc, ir, retired, fault, mem_req, mem_wr, reg_wr} !== {3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got st=%0d pc=%h ir=%h ret=%0d flt=%b req=%b wr=%b rw=%b, want 0 0 0 0 0 1 0 0",
                  state, pc, ir, retired, fault, mem_req, mem_wr, reg_wr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mpc = '0;
      mir = '0;
      mret = '0;
      q.delete();
   endtask

   task automatic expect_pc(string name, logic [31:0] want);
      n_chk++;
      if (pc !== want) begin
         n_fail++;
         $display("FAIL %s: got pc=%h, want %h", name, pc, want);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({state, pc, ir, retired, fault, mem_req} !== {3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_hold: got st=%0d pc=%h ir=%h ret=%0d flt=%b req=%b", state, pc, ir, retired, fault, mem_req);
      end
      rst_n = 1'b1;
      mpc = '0;
      mir = '0;
      mret = '0;
   endtask

   task automatic test_add();
      run("add", 32'h01095020, 0, 0, 0, 0);
      expect_pc("add_pc", 32'h4);
   endtask

   task automatic test_lw();
      run("lw", {6'h23, 5'd1, 5'd2, 16'h0010}, 0, 3, 0, 0);
      run("sw", {6'h2B, 5'd1, 5'd2, 16'h0020}, 2, 1, 0, 0);
   endtask

   task automatic test_beq();
      do_reset();
      for (int k = 0; k < 4; k++) run("addi", {6'h08, 26'h0421234}, 0, 0, 0, 0);
      run("beq_taken", {6'h04, 10'd0, 16'hFFFF}, 0, 0, 1, 0);
      expect_pc("beq_taken_pc", 32'h10);
      run("beq_not", {6'h04, 10'd0, 16'hFFFF}, 0, 0, 0, 0);
      expect_pc("beq_not_pc", 32'h14);
      run("bne_taken", {6'h05, 10'd0, 16'h0003}, 1, 0, 0, 0);
      run("jr", {6'h00, 5'd3, 15'd0, 6'h08}, 0, 0, 0, 32'h0000_0203);
   endtask

   task automatic test_jal();
      do_reset();
      run("j", {6'h02, 26'h000010}, 0, 0, 0, 0);
      expect_pc("j_pc", 32'h40);
      run("jal", {6'h03, 26'h000100}, 0, 0, 0, 0);
      expect_pc("jal_pc", 32'h400);
   endtask

   task automatic test_bad_op();
      do_reset();
      run("xori", {6'h0E, 26'h1ABCDEF}, 0, 0, 0, 0);
      run("bad_op", {6'h3F, 26'h0}, 0, 0, 0, 0);
      n_chk++;
      if (retired !== 32'd1) begin
         n_fail++;
         $display("FAIL bad_op_retired: got %0d, want 1", retired);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      run("fetch_wait15", 32'h01095020, 15, 0, 0, 0);
      run("fetch_timeout", 32'h01095020, 16, 0, 0, 0);
      do_reset();
      run("mem_wait15", {6'h2B, 26'h0}, 0, 15, 0, 0);
      run("mem_timeout", {6'h2B, 26'h0}, 0, 16, 0, 0);
      do_reset();
      run("after_fault", 32'h01095020, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      instr_in = {6'h23, 26'h0};
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({state, mem_req} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_mem: got st=%0d req=%b, want 3 1", state, mem_req);
      end
      do_reset();
      n_chk++;
      if ({state, mem_req, pc} !== {3'd0, 1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL after_release: got st=%0d req=%b pc=%h, want 0 1 0", state, mem_req, pc);
      end
      run("post_mid", 32'h01095020, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(1, 12))
         1:       return {6'h23, w[25:0]};
         2:       return {6'h2B, w[25:0]};
         3:       return {6'h02, w[25:0]};
         4:       return {6'h03, w[25:0]};
         5:       return {6'h04, w[25:0]};
         6:       return {6'h05, w[25:0]};
         7:       return {6'h08, w[25:0]};
         8:       return {6'h0E, w[25:0]};
         9:       return {6'h00, w[25:6], 6'h20};
         10:      return {6'h00, w[25:6], 6'h22};
         11:      return {6'h00, w[25:6], 6'h2A};
         default: return {6'h00, w[25:6], 6'h08};
      endcase
   endfunction

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 150; n++) begin
         int fd, md;
         fd = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
         md = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
         run("random", rand_insn(), fd, md, 1'($urandom), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_beq();
      test_jal();
      test_bad_op();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
